// File: rtl/systolic_feed_ctrl.sv
// Load/feed sequencer for a bank of DIM row shift FIFOs that drive a systolic array.
// Steers a row-major DIM x DIM operand stream into the row FIFOs, then drains them with diagonal skew.
module systolic_feed_ctrl #(
    parameter int DIM  = 8,
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            wr_valid,
    input  logic [BITS-1:0] wr_data,
    output logic            wr_ready,
    output logic [DIM-1:0]  fifo_en,
    output logic [BITS-1:0] fifo_d,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(DIM);
    localparam int FW = $clog2(2 * DIM);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FEED = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIM - 1);
    localparam logic [FW-1:0] FEED_LAST = FW'(2 * DIM - 2);
    localparam logic [DIM-1:0] ROW0_SEL = {{(DIM-1){1'b0}}, 1'b1};

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] row_cnt;
    logic [CW-1:0] col_cnt;
    logic [FW-1:0] feed_cnt;

    logic accept;
    logic col_last;
    logic last_word;
    logic feed_last;

    assign accept    = (state == ST_LOAD) && wr_valid;
    assign col_last  = (col_cnt == CNT_LAST);
    assign last_word = accept && col_last && (row_cnt == CNT_LAST);
    assign feed_last = (state == ST_FEED) && (feed_cnt == FEED_LAST);

    // NOTE: every output is assigned a default first so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)     state_nxt = ST_LOAD;
            ST_LOAD: if (last_word) state_nxt = ST_FEED;
            ST_FEED: if (feed_last) state_nxt = ST_DONE;
            ST_DONE:                state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            row_cnt  <= '0;
            col_cnt  <= '0;
            feed_cnt <= '0;
        end else begin
            state <= state_nxt;

            // DIM is a power of two, so the column and row counters wrap naturally at DIM-1.
            if (accept) begin
                col_cnt <= col_cnt + 1'b1;
                if (col_last)
                    row_cnt <= row_cnt + 1'b1;
            end

            if (state == ST_FEED && !feed_last)
                feed_cnt <= feed_cnt + 1'b1;
            else
                feed_cnt <= '0;
        end
    end

    always_comb begin
        wr_ready = 1'b0;
        fifo_en  = '0;
        fifo_d   = '0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_LOAD: begin
                wr_ready = 1'b1;
                busy     = 1'b1;
                if (wr_valid) begin
                    fifo_en = ROW0_SEL << row_cnt;
                    fifo_d  = wr_data;
                end
            end
            ST_FEED: begin
                busy = 1'b1;
                // Row r shifts during the DIM-cycle window starting r cycles after row 0.
                for (int r = 0; r < DIM; r++)
                    fifo_en[r] = (int'(feed_cnt) >= r) && (int'(feed_cnt) <= r + DIM - 1);
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/systolic_feed_ctrl.md
Name: systolic_feed_ctrl

Overview:
Sequencing controller for a bank of DIM row delay buffers (shift FIFOs, depth DIM, BITS wide) that feed a systolic matrix array. It accepts a DIM x DIM operand matrix row-major over a valid/ready write port and steers each word into its row FIFO. It then shifts all row FIFOs with diagonal skew so that row r enters the array r cycles after row 0. The block produces only FIFO enables, the shared FIFO data input and status; it holds no matrix storage.

Parameters:
DIM, 8, number of row FIFOs, equal to FIFO depth and matrix dimension (power of 2, >=2)
BITS, 8, element width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a load/feed sequence
wr_valid  in  1  write word valid
wr_data  in  BITS  write word, row-major order (row 0 col 0 first)
wr_ready  out  1  controller accepts wr_data this cycle
fifo_en  out  DIM  per-row FIFO shift enable
fifo_d  out  BITS  shared data input to all row FIFOs
busy  out  1  high in LOAD and FEED
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0): state IDLE; row_cnt, col_cnt, feed_cnt = 0; wr_ready, fifo_en, busy, done = 0; fifo_d = 0. Reset mid-operation aborts immediately; no partial state survives.
- Outputs are combinational decodes of state, counters and wr_valid; there are no added output register stages.
- IDLE: start=1 -> LOAD on the next edge; otherwise stay. wr_valid is ignored and wr_ready=0.
- LOAD:
  - wr_ready=1.
  - Accept = wr_valid & wr_ready. On accept: fifo_en = one-hot bit row_cnt in the same cycle, fifo_d = wr_data, col_cnt increments.
  - When col_cnt wraps from DIM-1 to 0, row_cnt increments.
  - No accept: fifo_en=0, fifo_d=0, counters hold. Gaps of any length are legal.
  - Accept of word DIM*DIM-1 (row_cnt=DIM-1, col_cnt=DIM-1) -> FEED next edge, counters cleared.
- FEED:
  - wr_ready=0, fifo_d=0. Duration is 2*DIM-1 cycles; feed_cnt runs 0..2*DIM-2.
  - fifo_en[r]=1 iff r <= feed_cnt <= r+DIM-1, giving the skew.
  - On feed_cnt = 2*DIM-2 -> DONE next edge.
  - feed_cnt width is $clog2(2*DIM); no wrap occurs.
- DONE: done=1, busy=0, all enables 0, for exactly one cycle, then -> IDLE.
- start is ignored in LOAD, FEED and DONE; it is not queued.
- A start asserted in the same cycle as DONE is ignored. A new start is honoured from IDLE only, the cycle after DONE or later.
- Each row FIFO receives exactly DIM shifts in LOAD and exactly DIM shifts in FEED.

Test Plan:
- Reset: DIM=4, BITS=8, drive rst_n=0 mid-clock -> all outputs 0 immediately (without waiting for a clock edge); after release with no start, stay idle for 10 cycles with wr_ready=0.
- Contiguous load: start, then wr_data=1..16 with wr_valid held high -> fifo_en = 0001 for words 1-4, 0010 for 5-8, 0100 for 9-12, 1000 for 13-16; fifo_d equals wr_data on each accept; wr_ready=0 the cycle after word 16.
- Backpressure: same 16 words with wr_valid toggled 1,0,0,1,... -> fifo_en nonzero only on accept cycles; row boundaries are unchanged; exactly 16 enables total.
- Feed skew: after the load, the 7 FEED cycles show fifo_en = 0001, 0011, 0111, 1111, 1110, 1100, 1000 with fifo_d=0 and busy=1; the next cycle has done=1, busy=0; the cycle after, done=0. Per-row enable count in FEED is 4.
- Ignored start: pulse start during LOAD word 5 and during FEED cycle 2 -> sequence, counters and enables are unaffected; exactly one done pulse.
- Abort: assert rst_n=0 at FEED cycle 3 -> fifo_en and busy drop to 0 immediately; after release, start plus 16 words -> load restarts at row 0 (first enable 0001).
